lsu_bank_ctrl: RTL and testbench
================================

// Module: lsu_bank_ctrl
// PURPOSE
//  - Sits directly upstream of the even/odd dual-port byte-bank memory. It accepts one load or store per cycle over a
//    valid/ready request channel.
//  - Drives the four bank ports (even_1/2, odd_1/2): addresses, byte data and write enables.
//  - Handles byte/half/word accesses at any byte address, including misaligned ones, in a single bank access.
//  - Returns the extracted and extended load data, or a store ack, on a valid/ready response channel.
//    A skid register holds the response under backpressure.
// PARAMETERS
//  ADDR_W   16  byte-address width; byte space = 2**ADDR_W
//  BANK_AW  15  bank address width; must equal ADDR_W-1
// PORTS
//  i_clk            in   1   clock; all state updates on rising edge
//  i_reset          in   1   synchronous, active-high reset
//  i_req_valid      in   1   request valid
//  o_req_ready      out  1   request ready
//  i_req_we         in   1   1 = store, 0 = load
//  i_req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  i_req_unsigned   in   1   load: 1 = zero-extend, 0 = sign-extend
//  i_req_addr       in   16  byte address A
//  i_req_wdata      in   32  store data; byte k goes to address A+k
//  o_addr_even_1/2  out  15  even-bank port addresses
//  o_addr_odd_1/2   out  15  odd-bank port addresses
//  o_data_even_1/2, o_data_odd_1/2  out  8  bank write bytes
//  o_we_even_1/2, o_we_odd_1/2      out  1  bank write enables
//  o_lsu_addr       out  1   registered A[0] of the outstanding load; feeds the memory's lane mux
//  i_mem_data       in   32  memory o_data; byte k = mem[A+k]; valid the cycle after the access
//  o_rsp_valid      out  1   response valid
//  i_rsp_ready      in   1   response ready
//  o_rsp_rdata      out  32  load result; 0 for stores and for errors
//  o_rsp_err        out  1   access error
// BEHAVIOUR
//  - Reset: state = IDLE; o_rsp_valid, o_rsp_err, o_rsp_rdata, o_lsu_addr and the hold register all = 0;
//    all o_we_* = 0.
//  - Accept: a request is accepted when i_req_valid & o_req_ready.
//  - Bank addresses are combinational from the request, with H = A>>1:
//    - A[0]=0: even_1 = H, odd_1 = H, even_2 = H+1, odd_2 = H+1.
//    - A[0]=1: odd_1 = H, even_1 = H+1, odd_2 = H+1, even_2 = H+2.
//  - Byte-to-port lanes:
//    - A[0]=0: byte0→even_1, byte1→odd_1, byte2→even_2, byte3→odd_2.
//    - A[0]=1: byte0→odd_1, byte1→even_1, byte2→odd_2, byte3→even_2.
//  - Write enables: o_we_* = accept & we & lane < nbytes & ~err. nbytes = 1/2/4 for size 00/01/10.
//  - Error: err = (size==11) | (A + nbytes - 1 > 2**ADDR_W - 1), i.e. no wrap-around.
//    An erroring request is still accepted; it issues no write and returns rsp_err=1, rdata=0.
//  - Latency: response valid exactly 1 cycle after accept, for loads and stores alike.
//  - Load extract: bits [8*nbytes-1:0] of the memory data, zero- or sign-extended per i_req_unsigned.
//    Size, unsigned and err are registered at accept.
//  - FSM states and transitions:
//    - IDLE: o_rsp_valid=0, o_req_ready=1. Accept → RESP.
//    - RESP: o_rsp_valid=1; rdata is extracted live from i_mem_data.
//      - rsp_ready & accept → RESP (back-to-back, 1 op/cycle).
//      - rsp_ready & no accept → IDLE.
//      - ~rsp_ready → HOLD; the extracted data is captured into the hold register.
//      - o_req_ready = i_rsp_ready.
//    - HOLD: o_rsp_valid=1; rdata comes from the hold register; o_req_ready=0. rsp_ready → IDLE.
//  - Banks receive no accesses while in HOLD; the held data is therefore immune to later bank activity.
//  - Response outputs stay stable while o_rsp_valid & ~i_rsp_ready.
//  - A store followed by a load to the same address in the next cycle returns the new data.
//    This relies on the bank write completing at the store's accept edge.
//  - Reset mid-operation: a pending response is dropped and no write is issued in the reset cycle.
// STRUCTURE
//  - lsu_pkg:
//    - typedef enum logic[1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} lsu_size_e;
//    - typedef enum {IDLE, RESP, HOLD} lsu_state_e;
//    - function nbytes(lsu_size_e).
//  - Sub-module lsu_load_extract: combinational size/sign extraction of 32-bit memory data.
//  - Address/lane steering and the FSM stay in this module.
// TESTING
//  1. Reset mid-RESP with i_rsp_ready=0
//     → next cycle o_rsp_valid=0, state IDLE, all o_we_*=0.
//  2. Store word 0xDEADBEEF @0x0003, then load word @0x0003:
//     - store: o_we_odd_1/even_1/odd_2/even_2 = 1, odd_1 addr 0x0001 data 0xEF, even_2 addr 0x0003 data 0xDE;
//     - load: rdata = 0xDEADBEEF, 1-cycle latency.
//  3. Store byte 0x80 @0x0010; load byte signed → 0xFFFFFF80; load byte unsigned → 0x00000080.
//     Store half 0x1234 @0x0011 → only o_we_odd_1 and o_we_even_1 asserted.
//  4. Load word @0xFFFE → rsp_err=1, rdata=0, no o_we_*.
//     size=11 @0x0000 → rsp_err=1.
//     Load byte @0xFFFF → err=0.
//  5. Back-to-back: 4 loads with i_rsp_ready=1 → 4 responses on 4 consecutive cycles, o_req_ready held 1.
//  6. Load, then i_rsp_ready=0 for 3 cycles while the bank is overwritten via a second load attempt
//     → o_req_ready=0, rdata held stable; the first response is delivered unchanged on release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU bank controller: access sizes, FSM states
// and the size-to-byte-count mapping.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} lsu_size_e;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} lsu_state_e;

  // SZ_BAD always errors, so its byte count only has to be harmless.
  function automatic logic [2:0] nbytes(lsu_size_e size);
    case (size)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      SZ_W:    nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bank_ctrl_if.sv
// Request/response channel between a load/store client and the LSU bank controller.
interface lsu_bank_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_load_extract.sv
// Narrows 32-bit memory data to the access size and zero- or sign-extends it.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (size)
      SZ_B:    result = {{24{~is_unsigned & data[7]}}, data[7:0]};
      SZ_H:    result = {{16{~is_unsigned & data[15]}}, data[15:0]};
      SZ_W:    result = data;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bank_ctrl.sv
// Steers byte/half/word loads and stores at any byte address onto the even/odd dual-port
// byte banks in one access, and returns load data or a store ack through a one-entry skid.
//
// state | meaning
// IDLE  | no response pending; request channel open
// RESP  | response for last cycle's access on the bus; data taken live from the banks
// HOLD  | response stalled by the consumer; data held locally, no new accesses
module lsu_bank_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int BANK_AW = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  lsu_bank_ctrl_if.slave     bus,
  output logic [BANK_AW-1:0] o_addr_even_1,
  output logic [BANK_AW-1:0] o_addr_even_2,
  output logic [BANK_AW-1:0] o_addr_odd_1,
  output logic [BANK_AW-1:0] o_addr_odd_2,
  output logic [7:0]         o_data_even_1,
  output logic [7:0]         o_data_even_2,
  output logic [7:0]         o_data_odd_1,
  output logic [7:0]         o_data_odd_2,
  output logic               o_we_even_1,
  output logic               o_we_even_2,
  output logic               o_we_odd_1,
  output logic               o_we_odd_2,
  output logic               o_lsu_addr,
  input  logic [31:0]        i_mem_data
);

  localparam logic [ADDR_W:0] BYTE_SPACE = {1'b1, {ADDR_W{1'b0}}};

  lsu_state_e         state_q, state_d;
  lsu_size_e          req_size, size_q;
  logic [2:0]         req_nbytes;
  logic [ADDR_W:0]    end_excl;
  logic               req_err, accept, wr_en, odd_start;
  logic [BANK_AW-1:0] half, half_p1, half_p2;
  logic               uns_q, we_q, err_q;
  logic [31:0]        ext_rdata, live_rdata, hold_q;

  assign req_size   = lsu_size_e'(bus.req_size);
  assign req_nbytes = nbytes(req_size);
  assign end_excl   = {1'b0, bus.req_addr} + {{(ADDR_W-2){1'b0}}, req_nbytes};
  assign req_err    = (req_size == SZ_BAD) | (end_excl > BYTE_SPACE);

  // Reset gates acceptance so a write can never slip out in the reset cycle.
  assign bus.req_ready = ~i_reset & ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
  assign accept        = bus.req_valid & bus.req_ready & ~i_reset;
  assign wr_en         = accept & bus.req_we & ~req_err;

  assign odd_start = bus.req_addr[0];
  assign half      = bus.req_addr[ADDR_W-1:1];
  assign half_p1   = half + BANK_AW'(1);
  assign half_p2   = half + BANK_AW'(2);

  assign o_addr_odd_1  = half;
  assign o_addr_odd_2  = half_p1;
  assign o_addr_even_1 = odd_start ? half_p1 : half;
  assign o_addr_even_2 = odd_start ? half_p2 : half_p1;

  assign o_data_even_1 = odd_start ? bus.req_wdata[15:8]  : bus.req_wdata[7:0];
  assign o_data_odd_1  = odd_start ? bus.req_wdata[7:0]   : bus.req_wdata[15:8];
  assign o_data_even_2 = odd_start ? bus.req_wdata[31:24] : bus.req_wdata[23:16];
  assign o_data_odd_2  = odd_start ? bus.req_wdata[23:16] : bus.req_wdata[31:24];

  // Port k carries byte lane k or k^1; it writes only when that lane is inside the access.
  assign o_we_even_1 = wr_en & (odd_start ? (req_nbytes > 3'd1) : 1'b1);
  assign o_we_odd_1  = wr_en & (odd_start ? 1'b1 : (req_nbytes > 3'd1));
  assign o_we_even_2 = wr_en & (odd_start ? (req_nbytes > 3'd3) : (req_nbytes > 3'd2));
  assign o_we_odd_2  = wr_en & (odd_start ? (req_nbytes > 3'd2) : (req_nbytes > 3'd3));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: begin
        if (!bus.rsp_ready)  state_d = HOLD;
        else if (!accept)    state_d = IDLE;
      end
      HOLD: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= '0;
      o_lsu_addr <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q <= req_size;
        uns_q  <= bus.req_unsigned;
        we_q   <= bus.req_we;
        err_q  <= req_err;
        if (!bus.req_we) o_lsu_addr <= odd_start;
      end
      if ((state_q == RESP) && !bus.rsp_ready) hold_q <= live_rdata;
    end
  end

  lsu_load_extract u_extract (
    .data        (i_mem_data),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_rdata)
  );

  assign live_rdata    = (we_q | err_q) ? '0 : ext_rdata;
  assign bus.rsp_valid = (state_q != IDLE);
  assign bus.rsp_err   = (state_q != IDLE) & err_q;
  assign bus.rsp_rdata = (state_q == HOLD) ? hold_q :
                         (state_q == RESP) ? live_rdata : '0;

endmodule

// File: tb/tb_lsu_bank_ctrl.sv
// Bench for lsu_bank_ctrl: emulated byte banks, a flat-memory reference model,
// a directed vector table, hand-written corner sequences and random traffic.
module tb_lsu_bank_ctrl;
  import lsu_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    req_t        req;
    logic [3:0]  we_mask;   // {even_1, odd_1, even_2, odd_2}
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_bank_ctrl_if #(.ADDR_W(16)) bus ();

  logic [14:0] a_e1, a_e2, a_o1, a_o2;
  logic [7:0]  d_e1, d_e2, d_o1, d_o2;
  logic        we_e1, we_e2, we_o1, we_o2;
  logic        lsu_addr;
  logic [31:0] mem_data;

  lsu_bank_ctrl #(.ADDR_W(16), .BANK_AW(15)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .bus           (bus),
    .o_addr_even_1 (a_e1),
    .o_addr_even_2 (a_e2),
    .o_addr_odd_1  (a_o1),
    .o_addr_odd_2  (a_o2),
    .o_data_even_1 (d_e1),
    .o_data_even_2 (d_e2),
    .o_data_odd_1  (d_o1),
    .o_data_odd_2  (d_o2),
    .o_we_even_1   (we_e1),
    .o_we_even_2   (we_e2),
    .o_we_odd_1    (we_o1),
    .o_we_odd_2    (we_o2),
    .o_lsu_addr    (lsu_addr),
    .i_mem_data    (mem_data)
  );

  function automatic logic [7:0] init_byte(int a);
    return 8'((a * 37) ^ (a >> 7) ^ 8'h5b);
  endfunction

  // Dual-port byte banks: read-before-write, registered read data, lane mux on lsu_addr.
  logic [7:0] even_mem [0:32767];
  logic [7:0] odd_mem  [0:32767];
  logic [7:0] rd_e1, rd_e2, rd_o1, rd_o2;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      even_mem[i] = init_byte(2 * i);
      odd_mem[i]  = init_byte(2 * i + 1);
    end
    rd_e1 = 8'h0; rd_e2 = 8'h0; rd_o1 = 8'h0; rd_o2 = 8'h0;
    forever begin
      @(posedge clk);
      rd_e1 <= even_mem[a_e1];
      rd_e2 <= even_mem[a_e2];
      rd_o1 <= odd_mem[a_o1];
      rd_o2 <= odd_mem[a_o2];
      if (we_e1) even_mem[a_e1] <= d_e1;
      if (we_e2) even_mem[a_e2] <= d_e2;
      if (we_o1) odd_mem[a_o1]  <= d_o1;
      if (we_o2) odd_mem[a_o2]  <= d_o2;
    end
  end

  assign mem_data = lsu_addr ? {rd_e2, rd_o2, rd_e1, rd_o1} : {rd_o2, rd_e2, rd_o1, rd_e1};

  // Reference: flat byte memory plus at most one pending response.
  logic [7:0]  ref_mem [0:65535];
  logic        pend_valid, pend_fresh, pend_err;
  logic [31:0] pend_rdata;
  int          n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic req_t rq(logic we, logic [1:0] size, logic uns, logic [15:0] addr,
                              logic [31:0] wdata);
    req_t r;
    r.valid = 1'b1; r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [15:0] addr,
                              logic [31:0] wdata, logic [3:0] mask, logic err, logic [31:0] rdata);
    vec_t v;
    v.req = rq(we, size, uns, addr, wdata); v.we_mask = mask; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  // One clock: drive after the falling edge, check against the model, then advance the model.
  task automatic cycle(input req_t r, input logic rdy);
    logic        exp_ready, acc, err;
    logic [31:0] v;
    int          nb, wcnt, exp_wcnt;
    @(negedge clk);
    bus.req_valid    = r.valid;
    bus.req_we       = r.we;
    bus.req_size     = r.size;
    bus.req_unsigned = r.uns;
    bus.req_addr     = r.addr;
    bus.req_wdata    = r.wdata;
    bus.rsp_ready    = rdy;
    #1;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(pend_valid));
    if (pend_valid) begin
      chk("rsp_rdata", bus.rsp_rdata, pend_rdata);
      chk("rsp_err", 32'(bus.rsp_err), 32'(pend_err));
    end
    exp_ready = !pend_valid || (pend_fresh && rdy);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    acc      = r.valid && exp_ready;
    nb       = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
    err      = (r.size == 2'd3) || (int'(r.addr) + nb > 65536);
    wcnt     = int'(we_e1) + int'(we_o1) + int'(we_e2) + int'(we_o2);
    exp_wcnt = (acc && r.we && !err) ? nb : 0;
    chk("we_count", 32'(wcnt), 32'(exp_wcnt));
    if (pend_valid && rdy) pend_valid = 1'b0;
    else                   pend_fresh = 1'b0;
    if (acc) begin
      v = '0;
      if (!err) begin
        for (int k = 0; k < nb; k++) begin
          if (r.we) ref_mem[16'(int'(r.addr) + k)] = r.wdata[8*k +: 8];
          else      v[8*k +: 8] = ref_mem[16'(int'(r.addr) + k)];
        end
        if (!r.uns && nb == 1) v = {{24{v[7]}}, v[7:0]};
        if (!r.uns && nb == 2) v = {{16{v[15]}}, v[15:0]};
      end
      if (r.we || err) v = '0;
      pend_valid = 1'b1;
      pend_fresh = 1'b1;
      pend_rdata = v;
      pend_err   = err;
    end
  endtask

  req_t        idle_r, rnd_r;
  vec_t        vecs [14];
  logic [31:0] b2b_exp [4];
  req_t        b2b_req [4];

  initial begin
    n_cmp = 0; n_bad = 0;
    pend_valid = 1'b0; pend_fresh = 1'b0; pend_err = 1'b0; pend_rdata = '0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = init_byte(a);
    idle_r = '0;

    //          we    size  uns   addr      wdata          mask     err   rdata
    vecs[0]  = mk(1'b1, 2'd0, 1'b0, 16'h0010, 32'h0000_0080, 4'b1000, 1'b0, 32'h0000_0000);
    vecs[1]  = mk(1'b0, 2'd0, 1'b0, 16'h0010, 32'h0,         4'b0000, 1'b0, 32'hFFFF_FF80);
    vecs[2]  = mk(1'b0, 2'd0, 1'b1, 16'h0010, 32'h0,         4'b0000, 1'b0, 32'h0000_0080);
    vecs[3]  = mk(1'b1, 2'd1, 1'b0, 16'h0011, 32'h0000_1234, 4'b1100, 1'b0, 32'h0000_0000);
    vecs[4]  = mk(1'b0, 2'd1, 1'b1, 16'h0011, 32'h0,         4'b0000, 1'b0, 32'h0000_1234);
    vecs[5]  = mk(1'b0, 2'd0, 1'b1, 16'h0010, 32'h0,         4'b0000, 1'b0, 32'h0000_0080);
    vecs[6]  = mk(1'b0, 2'd2, 1'b0, 16'hFFFE, 32'h0,         4'b0000, 1'b1, 32'h0000_0000);
    vecs[7]  = mk(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'hCAFE_F00D, 4'b0000, 1'b1, 32'h0000_0000);
    vecs[8]  = mk(1'b0, 2'd3, 1'b0, 16'h0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0000);
    vecs[9]  = mk(1'b1, 2'd0, 1'b0, 16'hFFFF, 32'h0000_005A, 4'b0100, 1'b0, 32'h0000_0000);
    vecs[10] = mk(1'b0, 2'd0, 1'b1, 16'hFFFF, 32'h0,         4'b0000, 1'b0, 32'h0000_005A);
    vecs[11] = mk(1'b1, 2'd1, 1'b0, 16'hFFFE, 32'h0000_8001, 4'b1100, 1'b0, 32'h0000_0000);
    vecs[12] = mk(1'b0, 2'd1, 1'b0, 16'hFFFE, 32'h0,         4'b0000, 1'b0, 32'hFFFF_8001);
    vecs[13] = mk(1'b1, 2'd2, 1'b0, 16'h0020, 32'h1122_3344, 4'b1111, 1'b0, 32'h0000_0000);

    // Reset with a store presented: nothing may be written or accepted.
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 16'h0040; bus.req_wdata = 32'hA5A5_A5A5; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset lsu_addr", 32'(lsu_addr), 32'h0);
    chk("reset we", 32'({we_e1, we_o1, we_e2, we_o2}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;

    // Store word at an odd address and read it back.
    cycle(rq(1'b1, 2'd2, 1'b0, 16'h0003, 32'hDEAD_BEEF), 1'b1);
    chk("st_w we mask", 32'({we_e1, we_o1, we_e2, we_o2}), 32'hF);
    chk("st_w odd_1 addr", 32'(a_o1), 32'h1);
    chk("st_w odd_1 data", 32'(d_o1), 32'hEF);
    chk("st_w even_2 addr", 32'(a_e2), 32'h3);
    chk("st_w even_2 data", 32'(d_e2), 32'hDE);
    cycle(rq(1'b0, 2'd2, 1'b0, 16'h0003, 32'h0), 1'b1);
    cycle(idle_r, 1'b1);
    chk("ld_w valid", 32'(bus.rsp_valid), 32'h1);
    chk("ld_w rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].req, 1'b1);
      chk($sformatf("vec%0d we mask", i), 32'({we_e1, we_o1, we_e2, we_o2}), 32'(vecs[i].we_mask));
      cycle(idle_r, 1'b1);
      chk($sformatf("vec%0d rdata", i), bus.rsp_rdata, vecs[i].rdata);
      chk($sformatf("vec%0d err", i), 32'(bus.rsp_err), 32'(vecs[i].err));
    end

    // Four back-to-back loads, one response per cycle.
    b2b_req[0] = rq(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0); b2b_exp[0] = 32'h1122_3344;
    b2b_req[1] = rq(1'b0, 2'd0, 1'b1, 16'h0021, 32'h0); b2b_exp[1] = 32'h0000_0033;
    b2b_req[2] = rq(1'b0, 2'd1, 1'b1, 16'h0022, 32'h0); b2b_exp[2] = 32'h0000_1122;
    b2b_req[3] = rq(1'b0, 2'd0, 1'b0, 16'h0023, 32'h0); b2b_exp[3] = 32'h0000_0011;
    for (int i = 0; i < 4; i++) begin
      cycle(b2b_req[i], 1'b1);
      chk($sformatf("b2b%0d req_ready", i), 32'(bus.req_ready), 32'h1);
      if (i > 0) chk($sformatf("b2b%0d rdata", i - 1), bus.rsp_rdata, b2b_exp[i-1]);
    end
    cycle(idle_r, 1'b1);
    chk("b2b3 rdata", bus.rsp_rdata, b2b_exp[3]);

    // Stalled response while other loads are presented to the banks.
    cycle(rq(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(rq(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0), 1'b0);
      chk($sformatf("hold%0d req_ready", i), 32'(bus.req_ready), 32'h0);
      chk($sformatf("hold%0d rdata", i), bus.rsp_rdata, 32'h1122_3344);
    end
    cycle(idle_r, 1'b1);
    chk("hold release rdata", bus.rsp_rdata, 32'h1122_3344);
    cycle(idle_r, 1'b1);
    chk("hold done valid", 32'(bus.rsp_valid), 32'h0);

    // Reset while a response is pending and stalled.
    cycle(rq(1'b0, 2'd0, 1'b1, 16'h0021, 32'h0), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 16'h0030;
    #1;
    chk("mid-reset we", 32'({we_e1, we_o1, we_e2, we_o2}), 32'h0);
    chk("mid-reset req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("post-reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("post-reset req_ready", 32'(bus.req_ready), 32'h1);
    chk("post-reset lsu_addr", 32'(lsu_addr), 32'h0);
    pend_valid = 1'b0;
    pend_fresh = 1'b0;

    for (int i = 0; i < 800; i++) begin
      rnd_r.valid = ($urandom_range(0, 9) < 7);
      rnd_r.we    = ($urandom_range(0, 9) < 4);
      rnd_r.size  = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rnd_r.uns   = 1'($urandom_range(0, 1));
      rnd_r.addr  = ($urandom_range(0, 7) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                               : 16'($urandom_range(0, 63));
      rnd_r.wdata = $urandom;
      cycle(rnd_r, ($urandom_range(0, 3) != 0));
    end
    cycle(idle_r, 1'b1);
    cycle(idle_r, 1'b1);
    cycle(idle_r, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
